// File: rtl/flash_access_arbiter_pkg.sv
// Shared types for the flash access arbiter: FSM states, owner encoding
// and the round-robin grant decision.
package flash_access_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef logic owner_t;

    localparam owner_t OWN_N = 1'b0;
    localparam owner_t OWN_H = 1'b1;

    // Single requester wins outright; on contention the one not served last wins.
    function automatic owner_t pick_owner(input logic n_req, input logic h_req,
                                          input owner_t last_owner);
        if (n_req && h_req) begin
            return (last_owner == OWN_N) ? OWN_H : OWN_N;
        end else if (h_req) begin
            return OWN_H;
        end
        return OWN_N;
    endfunction

endpackage

// File: rtl/flash_access_arbiter_flex_counter.sv
// Clearable up-counter with a period of rollover_val counts (0..rollover_val-1);
// rollover_flag is high while the count holds the last value of the period.
module flash_access_arbiter_flex_counter #(
    parameter int unsigned N_BITS = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              count_enable,
    input  logic [N_BITS-1:0] rollover_val,
    output logic [N_BITS-1:0] count_out,
    output logic              rollover_flag
);

    logic [N_BITS-1:0] count_next;
    logic [N_BITS-1:0] last_val;

    assign last_val = rollover_val - N_BITS'(1);

    // Next count: clear has priority over counting.
    always_comb begin
        count_next = count_out;
        if (clear) begin
            count_next = '0;
        end else if (count_enable) begin
            count_next = (count_out == last_val) ? '0 : count_out + N_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
        end else begin
            count_out     <= count_next;
            rollover_flag <= (count_next == last_val);
        end
    end

endmodule

// File: rtl/flash_access_arbiter.sv
// Round-robin arbiter sharing the weight/bias flash port between the network
// sequencer (read-only) and the host loader (read/write), one access at a time.
module flash_access_arbiter
    import flash_access_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned ACCESS_CYCLES = 11
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              n_req,
    input  logic [ADDR_W-1:0] n_addr,
    output logic              n_done,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              flash_en,
    output logic              flash_we,
    output logic [ADDR_W-1:0] flash_addr,
    output logic [DATA_W-1:0] flash_wdata,
    input  logic [DATA_W-1:0] flash_rdata
);

    localparam int unsigned CNT_W = $clog2(ACCESS_CYCLES + 1);

    state_t           state;
    state_t           state_next;
    owner_t           owner;
    owner_t           last_owner;
    owner_t           grant_owner_c;
    logic             grant_c;
    logic             grant_we_c;
    logic             last_cycle_c;
    logic             we_q;
    logic             rollover_flag;
    logic [CNT_W-1:0] cnt;

    flash_access_arbiter_flex_counter #(
        .N_BITS(CNT_W)
    ) u_access_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (grant_c),
        .count_enable (state == ACCESS),
        .rollover_val (CNT_W'(ACCESS_CYCLES)),
        .count_out    (cnt),
        .rollover_flag(rollover_flag)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and grant decision; arbitration only happens in IDLE.
    always_comb begin
        state_next    = state;
        grant_c       = 1'b0;
        grant_owner_c = OWN_N;
        grant_we_c    = 1'b0;
        unique case (state)
            IDLE: begin
                if (n_req || h_req) begin
                    grant_c       = 1'b1;
                    grant_owner_c = pick_owner(n_req, h_req, last_owner);
                    grant_we_c    = (grant_owner_c == OWN_H) && h_we;
                    state_next    = ACCESS;
                end
            end
            ACCESS: begin
                if (rollover_flag) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign last_cycle_c = (state == ACCESS) && (cnt == CNT_W'(ACCESS_CYCLES - 1));

    // Latched access, read capture and registered outputs decoded from state_next.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            owner       <= OWN_N;
            last_owner  <= OWN_H;
            we_q        <= 1'b0;
            flash_addr  <= '0;
            flash_wdata <= '0;
            rdata       <= '0;
            flash_en    <= 1'b0;
            flash_we    <= 1'b0;
            busy        <= 1'b0;
            n_done      <= 1'b0;
            h_done      <= 1'b0;
        end else begin
            if (grant_c) begin
                owner       <= grant_owner_c;
                we_q        <= grant_we_c;
                flash_addr  <= (grant_owner_c == OWN_H) ? h_addr : n_addr;
                flash_wdata <= grant_we_c ? h_wdata : '0;
            end
            if (last_cycle_c) begin
                last_owner <= owner;
                if (!we_q) begin
                    rdata <= flash_rdata;
                end
            end
            flash_en <= (state_next == ACCESS);
            flash_we <= (state_next == ACCESS) && (grant_c ? grant_we_c : we_q);
            busy     <= (state_next != IDLE);
            n_done   <= (state_next == DONE) && (owner == OWN_N);
            h_done   <= (state_next == DONE) && (owner == OWN_H);
        end
    end

endmodule

// File: tb/tb_flash_access_arbiter.sv
// Directed bench for flash_access_arbiter: single-access vector table plus
// contention, mid-access reset and dropped-request sequences.
module tb_flash_access_arbiter;

    localparam int unsigned ACC = 11;
    localparam int unsigned LAT = ACC + 1;

    logic        clk;
    logic        n_rst;
    logic        n_req;
    logic [15:0] n_addr;
    logic        n_done;
    logic        h_req;
    logic        h_we;
    logic [15:0] h_addr;
    logic [15:0] h_wdata;
    logic        h_done;
    logic [15:0] rdata;
    logic        busy;
    logic        flash_en;
    logic        flash_we;
    logic [15:0] flash_addr;
    logic [15:0] flash_wdata;
    logic [15:0] flash_rdata;
    logic [15:0] frd;

    int tests = 0;
    int fails = 0;

    flash_access_arbiter dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .n_req      (n_req),
        .n_addr     (n_addr),
        .n_done     (n_done),
        .h_req      (h_req),
        .h_we       (h_we),
        .h_addr     (h_addr),
        .h_wdata    (h_wdata),
        .h_done     (h_done),
        .rdata      (rdata),
        .busy       (busy),
        .flash_en   (flash_en),
        .flash_we   (flash_we),
        .flash_addr (flash_addr),
        .flash_wdata(flash_wdata),
        .flash_rdata(flash_rdata)
    );

    // Flash model: data only valid while the strobe is up.
    assign flash_rdata = flash_en ? frd : 16'hDEAD;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        nr;
        logic        hr;
        logic        hwe;
        logic [15:0] na;
        logic [15:0] ha;
        logic [15:0] hwd;
        logic [15:0] frd;
        logic        exp_n;
        logic [15:0] ea;
        logic        ewe;
        logic [15:0] erd;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        n_req = 1'b0;
        h_req = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    // Requests must already be driven; runs until a done pulse or a cycle budget.
    task automatic run_access(input logic [15:0] ea, input logic ewe, input logic [15:0] ewd,
                              input int drop_at, output int lat, output int en_cyc,
                              output int nd, output int hd, output int bad);
        lat = 0; en_cyc = 0; nd = 0; hd = 0; bad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (flash_en) begin
                en_cyc++;
                if (flash_addr !== ea || flash_we !== ewe || (ewe && flash_wdata !== ewd)) bad++;
            end else if (flash_we) begin
                bad++;
            end
            if (k == 2) begin
                n_addr  = ~n_addr;
                h_addr  = ~h_addr;
                h_wdata = ~h_wdata;
                h_we    = ~h_we;
            end
            if (k == drop_at) begin
                n_req = 1'b0;
                h_req = 1'b0;
            end
            if (n_done) nd++;
            if (h_done) hd++;
            if (n_done || h_done) begin
                lat   = k;
                n_req = 1'b0;
                h_req = 1'b0;
                break;
            end
        end
    endtask

    task automatic post_checks(input string tag);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, {30'd0, n_done, h_done}, 32'd0);
        chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, en_cyc, nd, hd, bad;
        int idx, k, gap_low;
        int seq_owner[6];
        int seq_cyc[6];
        int seq_gap[6];

        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'hA5C3,
                    1'b1, 16'h0010, 1'b0, 16'hA5C3};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0200, 16'h0000, 16'h5A5A,
                    1'b0, 16'h0200, 1'b0, 16'h5A5A};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0033, 16'h1234, 16'hFFFF,
                    1'b0, 16'h0033, 1'b1, 16'h5A5A};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0077, 16'hBEEF, 16'h0001,
                    1'b1, 16'hFFFF, 1'b0, 16'h0001};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'h7777,
                    1'b0, 16'h0000, 1'b1, 16'h0001};

        n_rst = 1'b0; n_req = 1'b0; h_req = 1'b0; h_we = 1'b0;
        n_addr = '0; h_addr = '0; h_wdata = '0; frd = '0;

        @(negedge clk);
        chk("reset_outputs", {8'd0, n_done, h_done, busy, flash_en, flash_we, 3'd0},
            32'd0);
        chk("reset_data", {flash_addr, flash_wdata ^ rdata}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // Single-access table.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_addr  = vecs[i].na;
            h_addr  = vecs[i].ha;
            h_wdata = vecs[i].hwd;
            h_we    = vecs[i].hwe;
            frd     = vecs[i].frd;
            n_req   = vecs[i].nr;
            h_req   = vecs[i].hr;
            run_access(vecs[i].ea, vecs[i].ewe, vecs[i].hwd, 0, lat, en_cyc, nd, hd, bad);
            chk($sformatf("v%0d_latency", i), lat, LAT);
            chk($sformatf("v%0d_en_cycles", i), en_cyc, ACC);
            chk($sformatf("v%0d_n_done", i), nd, vecs[i].exp_n ? 1 : 0);
            chk($sformatf("v%0d_h_done", i), hd, vecs[i].exp_n ? 0 : 1);
            chk($sformatf("v%0d_bus_bad", i), bad, 0);
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].erd);
            post_checks($sformatf("v%0d", i));
        end

        // Both requesting from reset: N first, then strict alternation.
        do_reset();
        @(negedge clk);
        n_addr = 16'h0010; h_addr = 16'h0200; h_we = 1'b0; frd = 16'h1111;
        n_req = 1'b1; h_req = 1'b1;
        idx = 0; k = 0; gap_low = 0;
        for (int i = 0; i < 6; i++) begin
            seq_owner[i] = 2; seq_cyc[i] = 0; seq_gap[i] = -1;
        end
        while (idx < 6 && k < 200) begin
            @(negedge clk);
            k++;
            if (n_done || h_done) begin
                seq_owner[idx] = h_done ? 1 : 0;
                seq_cyc[idx]   = k;
                seq_gap[idx]   = gap_low;
                gap_low = 0;
                idx++;
            end else if (!busy) begin
                gap_low++;
            end
        end
        n_req = 1'b0; h_req = 1'b0;
        chk("rr_first_done_cycle", seq_cyc[0], LAT);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr_owner_%0d", i), seq_owner[i], i % 2);
        end
        for (int i = 1; i < 6; i++) begin
            chk($sformatf("rr_interval_%0d", i), seq_cyc[i] - seq_cyc[i-1], LAT + 1);
            chk($sformatf("rr_busy_gap_%0d", i), seq_gap[i], 1);
        end
        post_checks("rr");

        // Reset during ACCESS cycle 5, then a full restart.
        @(negedge clk);
        n_addr = 16'h0040; frd = 16'h2468; n_req = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_mid_en_before", {31'd0, flash_en}, 32'd1);
        #2 n_rst = 1'b0;
        #1;
        chk("rst_mid_async_drop", {29'd0, flash_en, busy, n_done}, 32'd0);
        @(negedge clk);
        chk("rst_mid_no_done", {30'd0, n_done, h_done}, 32'd0);
        n_rst = 1'b1;
        run_access(16'h0040, 1'b0, 16'h0000, 0, lat, en_cyc, nd, hd, bad);
        chk("rst_restart_latency", lat, LAT);
        chk("rst_restart_en_cycles", en_cyc, ACC);
        chk("rst_restart_n_done", nd, 1);
        chk("rst_restart_rdata", rdata, 16'h2468);
        post_checks("rst");

        // Request dropped at ACCESS cycle 3: access still completes.
        @(negedge clk);
        n_addr = 16'h0050; frd = 16'h0F0F; n_req = 1'b1;
        run_access(16'h0050, 1'b0, 16'h0000, 3, lat, en_cyc, nd, hd, bad);
        chk("drop_latency", lat, LAT);
        chk("drop_n_done", nd, 1);
        chk("drop_en_cycles", en_cyc, ACC);
        chk("drop_rdata", rdata, 16'h0F0F);
        post_checks("drop");
        @(negedge clk);
        chk("drop_stays_idle", {31'd0, busy | flash_en}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/flash_access_arbiter.md
Name: flash_access_arbiter

Overview:
- Shares the single weight/bias flash port between two requesters.
- Requester N is the network sequencer (read-only weight/bias fetch). Requester H is the host loader (read and write, for programming and readback).
- Grants one fixed-latency access at a time and enforces round-robin fairness.
- Returns registered read data with a one-cycle done pulse to the owner.

Parameters:
ADDR_W, 16, flash address width
DATA_W, 16, flash data width (four packed 4-bit weights)
ACCESS_CYCLES, 11, cycles flash_en is held per access; legal range 1..255

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
n_req  in  1  network request, level; held until n_done
n_addr  in  ADDR_W  network read address; sampled at grant
n_done  out  1  one-cycle pulse; rdata valid this cycle
h_req  in  1  host request, level; held until h_done
h_we  in  1  host write (1) / read (0); sampled at grant
h_addr  in  ADDR_W  host address; sampled at grant
h_wdata  in  DATA_W  host write data; sampled at grant
h_done  out  1  one-cycle pulse; rdata valid on reads
rdata  out  DATA_W  registered read data; holds until next read completes
busy  out  1  high in ACCESS and DONE
flash_en  out  1  flash access strobe
flash_we  out  1  flash write strobe
flash_addr  out  ADDR_W  latched address
flash_wdata  out  DATA_W  latched write data
flash_rdata  in  DATA_W  flash read data; valid on last ACCESS cycle

Behaviour:
- Reset values: all outputs 0; state IDLE; cnt 0; last_owner = H, so N wins the first contention.
- States:
  - IDLE: if no req, stay. If one req, grant it. If both, grant the requester != last_owner. On grant, latch owner, we (0 for N), addr, wdata; cnt <= 0; go to ACCESS.
  - ACCESS: flash_en = 1; flash_we = latched we; flash_addr/flash_wdata = latched values. cnt increments each cycle. On cnt == ACCESS_CYCLES-1: rdata <= flash_rdata if the access is a read (rdata unchanged on write); last_owner <= owner; go to DONE.
  - DONE: flash_en = 0; owner's done = 1 for exactly this cycle; go to IDLE unconditionally.
- Latency: req first high in IDLE cycle t → flash_en high cycles t+1..t+ACCESS_CYCLES → done at t+ACCESS_CYCLES+1. With the default this is 12 cycles.
- Requester rules:
  - Deassert req on the cycle done is seen. A req still high in the following IDLE cycle is a new request.
  - Address and data inputs may change after grant without effect.
- Req dropped mid-ACCESS: the access completes and done still pulses. No abort.
- Req arriving during ACCESS/DONE: waits; arbitration happens only in IDLE.
- Both requesters continuously requesting: strict alternation N,H,N,H. Neither waits more than one access.
- flash_we is never 1 for an N access.
- Reset mid-access: all outputs 0 asynchronously; no done is issued; the interrupted access is lost and the requester must re-request.
- Counter is sized $clog2(ACCESS_CYCLES+1) and never wraps within an access.

Decomposition:
- Shared package: state enum {IDLE, ACCESS, DONE} and owner constants OWN_N = 0, OWN_H = 1.
- Sub-module: the existing flex_counter serves as the access cycle counter.
  - rollover_val = ACCESS_CYCLES
  - count_enable = in ACCESS
  - clear on grant
  - rollover_flag drives the ACCESS→DONE transition

Test Plan:
1. Reset release; n_req=1, n_addr=0x0010, flash model returns 0xA5C3 → flash_en cycles 1-11; n_done at cycle 12; rdata=0xA5C3; h_done never set.
2. n_req and h_req rise together (h_we=0, h_addr=0x0200) → N served first (done cycle 12); H granted in the next IDLE; h_done 13 cycles after n_done.
3. Both held continuously for 6 accesses → done sequence N,H,N,H,N,H; busy low exactly one cycle between accesses.
4. Host write h_addr=0x0033, h_wdata=0x1234 → flash_we=1 for all 11 ACCESS cycles with those values; h_done pulses; rdata unchanged from prior read.
5. n_rst asserted at ACCESS cycle 5 → flash_en/busy drop immediately; no n_done; after release with n_req still high, a full 12-cycle access restarts.
6. n_req dropped at ACCESS cycle 3 → access completes, n_done still pulses once; next IDLE is idle with busy=0.
